// File: rtl/superh16_fetch_queue.sv
// superh16_fetch_queue: circular instruction buffer between fetch and decode.
// Each fetch group is cut after its first valid predicted-taken lane, and the
// surviving lanes are packed in lane order at the tail. Up to DEQ_WIDTH of the
// oldest entries are presented to decode. Backpressure is driven only by the
// registered entry count.
module superh16_fetch_queue #(
  parameter int ENQ_WIDTH   = 12,
  parameter int DEQ_WIDTH   = 12,
  parameter int DEPTH       = 32,
  parameter int VADDR_WIDTH = 64,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1,
  localparam int TAKE_W = $clog2(DEQ_WIDTH + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic [ENQ_WIDTH-1:0]                    fetch_valid,
  input  logic [ENQ_WIDTH-1:0][31:0]              fetch_inst,
  input  logic [ENQ_WIDTH-1:0][VADDR_WIDTH-1:0]   fetch_pc,
  input  logic [ENQ_WIDTH-1:0]                    fetch_pred_taken,
  input  logic [ENQ_WIDTH-1:0][VADDR_WIDTH-1:0]   fetch_pred_target,
  output logic                                    fetch_stall,
  output logic [DEQ_WIDTH-1:0]                    dec_valid,
  output logic [DEQ_WIDTH-1:0][31:0]              dec_inst,
  output logic [DEQ_WIDTH-1:0][VADDR_WIDTH-1:0]   dec_pc,
  output logic [DEQ_WIDTH-1:0]                    dec_pred_taken,
  output logic [DEQ_WIDTH-1:0][VADDR_WIDTH-1:0]   dec_pred_target,
  input  logic [TAKE_W-1:0]                       dec_take,
  output logic [CNT_W-1:0]                        occupancy
);

  // Canonical RISC-V NOP (addi x0,x0,0), driven on lanes that hold no entry.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [31:0]            mem_inst [DEPTH];
  logic [VADDR_WIDTH-1:0] mem_pc   [DEPTH];
  logic                   mem_tk   [DEPTH];
  logic [VADDR_WIDTH-1:0] mem_tgt  [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [ENQ_WIDTH-1:0]            keep;
  logic [ENQ_WIDTH-1:0][CNT_W-1:0] pos;
  logic [ENQ_WIDTH-1:0][PTR_W-1:0] wr_idx;
  logic [CNT_W-1:0]                kept_cnt;
  logic                            taken_seen;
  logic                            enq_fire;
  logic [CNT_W-1:0]                n_enq;
  logic [CNT_W-1:0]                n_deq;
  logic [CNT_W-1:0]                free_slots;

  // Backpressure uses the registered count only: a same-cycle dequeue earns no credit.
  assign free_slots  = CNT_W'(DEPTH) - count_reg;
  assign fetch_stall = free_slots < CNT_W'(ENQ_WIDTH);
  assign occupancy   = count_reg;
  assign enq_fire    = !flush && !fetch_stall && (|fetch_valid);
  assign n_enq       = enq_fire ? kept_cnt : '0;

  // Scan lanes low to high: keep valid lanes up to and including the first
  // valid predicted-taken lane, and give each kept lane its packed offset.
  always_comb begin
    taken_seen = 1'b0;
    kept_cnt   = '0;
    keep       = '0;
    pos        = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      keep[i] = fetch_valid[i] && !taken_seen;
      pos[i]  = kept_cnt;
      if (keep[i]) kept_cnt = kept_cnt + 1'b1;
      if (fetch_valid[i] && fetch_pred_taken[i]) taken_seen = 1'b1;
    end
  end

  // Slot addresses for kept lanes, wrapping naturally through the pointer width.
  for (genvar gi = 0; gi < ENQ_WIDTH; gi++) begin : g_wr_idx
    assign wr_idx[gi] = tail_reg + pos[gi][PTR_W-1:0];
  end

  // Dequeue count: decode's request clamped to what is present and presentable.
  always_comb begin
    n_deq = CNT_W'(dec_take);
    if (n_deq > count_reg) n_deq = count_reg;
    if (n_deq > CNT_W'(DEQ_WIDTH)) n_deq = CNT_W'(DEQ_WIDTH);
  end

  // Next pointer/count; flush empties the queue and overrides both ports.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      head_next  = head_reg + n_deq[PTR_W-1:0];
      tail_next  = tail_reg + n_enq[PTR_W-1:0];
      count_next = count_reg + n_enq - n_deq;
    end
  end

  // Pointer and count registers; reset loses every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entry storage: contents need no reset, validity comes from count.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (keep[i]) begin
          mem_inst[wr_idx[i]] <= fetch_inst[i];
          mem_pc[wr_idx[i]]   <= fetch_pc[i];
          mem_tk[wr_idx[i]]   <= fetch_pred_taken[i];
          mem_tgt[wr_idx[i]]  <= fetch_pred_target[i];
        end
      end
    end
  end

  // Decode lane gi shows entry head+gi, or a NOP when fewer entries exist.
  for (genvar gi = 0; gi < DEQ_WIDTH; gi++) begin : g_dec
    logic [PTR_W-1:0] rd_idx;
    assign rd_idx              = head_reg + PTR_W'(gi);
    assign dec_valid[gi]       = CNT_W'(gi) < count_reg;
    assign dec_inst[gi]        = dec_valid[gi] ? mem_inst[rd_idx] : NOP_INST;
    assign dec_pc[gi]          = dec_valid[gi] ? mem_pc[rd_idx]   : '0;
    assign dec_pred_taken[gi]  = dec_valid[gi] ? mem_tk[rd_idx]   : 1'b0;
    assign dec_pred_target[gi] = dec_valid[gi] ? mem_tgt[rd_idx]  : '0;
  end

  // Decode must never ask for more entries than are present.
  a_take_le_count : assert property (@(posedge clk) disable iff (rst || flush)
                                     CNT_W'(dec_take) <= count_reg);

endmodule

// File: tb/tb_superh16_fetch_queue.sv
// Bench for superh16_fetch_queue: a scoreboard queue holds the entries the
// queue should contain, oldest first; each test compares the decode lanes,
// occupancy and fetch_stall against it.
module tb_superh16_fetch_queue;

  localparam int EW = 12;
  localparam int DW = 12;
  localparam int DP = 32;
  localparam int VW = 64;

  typedef struct packed {
    logic [31:0]   inst;
    logic [VW-1:0] pc;
    logic          tk;
    logic [VW-1:0] tgt;
  } ent_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     flush;
  logic [EW-1:0]            fetch_valid;
  logic [EW-1:0][31:0]      fetch_inst;
  logic [EW-1:0][VW-1:0]    fetch_pc;
  logic [EW-1:0]            fetch_pred_taken;
  logic [EW-1:0][VW-1:0]    fetch_pred_target;
  logic                     fetch_stall;
  logic [DW-1:0]            dec_valid;
  logic [DW-1:0][31:0]      dec_inst;
  logic [DW-1:0][VW-1:0]    dec_pc;
  logic [DW-1:0]            dec_pred_taken;
  logic [DW-1:0][VW-1:0]    dec_pred_target;
  logic [3:0]               dec_take;
  logic [5:0]               occupancy;

  int errors = 0;
  int checks = 0;
  ent_t sb[$];
  ent_t pend[$];

  superh16_fetch_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
    .fetch_pred_taken(fetch_pred_taken), .fetch_pred_target(fetch_pred_target),
    .fetch_stall(fetch_stall),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .dec_pred_taken(dec_pred_taken), .dec_pred_target(dec_pred_target),
    .dec_take(dec_take), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Present a fetch group and record which lanes should survive truncation.
  task automatic drive_group(input logic [VW-1:0] base, input logic [EW-1:0] v,
                             input logic [EW-1:0] tk, input logic [VW-1:0] tgt);
    bit cut = 1'b0;
    ent_t e;
    pend.delete();
    for (int i = 0; i < EW; i++) begin
      fetch_valid[i]       = v[i];
      fetch_pc[i]          = base + VW'(4 * i);
      fetch_inst[i]        = $urandom;
      fetch_pred_taken[i]  = tk[i];
      fetch_pred_target[i] = tk[i] ? tgt : (64'hDEAD_0000 + VW'(i));
      if (v[i] && !cut) begin
        e.inst = fetch_inst[i]; e.pc = fetch_pc[i];
        e.tk = tk[i]; e.tgt = fetch_pred_target[i];
        pend.push_back(e);
      end
      if (v[i] && tk[i]) cut = 1'b1;
    end
  endtask

  // One clock: update the scoreboard for this cycle's controls, then advance.
  task automatic step(input int take, input bit fl, input bit rs);
    int n;
    bit stall_m;
    dec_take = 4'(take);
    flush    = fl;
    rst      = rs;
    stall_m  = (DP - sb.size()) < EW;
    if (rs || fl) begin
      sb.delete();
    end else begin
      n = take;
      if (n > sb.size()) n = sb.size();
      if (n > DW) n = DW;
      repeat (n) void'(sb.pop_front());
      if (!stall_m) foreach (pend[k]) sb.push_back(pend[k]);
    end
    pend.delete();
    @(posedge clk);
    #1;
    fetch_valid = '0;
    dec_take    = '0;
    flush       = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic test_reset();
    fetch_valid = '0; fetch_pred_taken = '0; fetch_inst = '0;
    fetch_pc = '0; fetch_pred_target = '0;
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    checks++;
    if (occupancy !== 6'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++;
    if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", fetch_stall); end
    checks++;
    if (dec_valid !== '0) begin errors++; $display("FAIL reset_valid got=%h exp=0", dec_valid); end
    checks++;
    if (dec_inst[0] !== 32'h13 || dec_pc[0] !== '0) begin
      errors++; $display("FAIL reset_nop got=%h/%h exp=13/0", dec_inst[0], dec_pc[0]);
    end
    $display("test_reset done: occ=%0d", occupancy);
  endtask

  task automatic test_basic();
    drive_group(64'h8000_0000, 12'hFFF, 12'h000, '0);
    step(0, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 6'd12) begin errors++; $display("FAIL basic_occ got=%0d exp=12", occupancy); end
    checks++;
    if (dec_valid !== 12'hFFF) begin errors++; $display("FAIL basic_valid got=%h exp=fff", dec_valid); end
    checks++;
    if (dec_pc[11] !== 64'h8000_002C) begin errors++; $display("FAIL basic_pc11 got=%h exp=8000002c", dec_pc[11]); end
    for (int i = 0; i < DW; i++) begin
      checks++;
      if ({dec_inst[i], dec_pc[i], dec_pred_taken[i], dec_pred_target[i]} !== sb[i]) begin
        errors++; $display("FAIL basic_lane%0d got=%h exp=%h", i,
          {dec_inst[i], dec_pc[i], dec_pred_taken[i], dec_pred_target[i]}, sb[i]);
      end
    end
    step(12, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 6'd0 || dec_valid !== '0) begin
      errors++; $display("FAIL basic_drain got=%0d/%h exp=0/0", occupancy, dec_valid);
    end
    $display("test_basic done: occ=%0d", occupancy);
  endtask

  task automatic test_truncate();
    drive_group(64'h8000_1000, 12'hFFF, 12'h008, 64'h9000_0000);
    step(0, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 6'd4) begin errors++; $display("FAIL trunc_occ got=%0d exp=4", occupancy); end
    checks++;
    if (dec_valid !== 12'h00F) begin errors++; $display("FAIL trunc_valid got=%h exp=00f", dec_valid); end
    checks++;
    if (dec_pred_taken[3] !== 1'b1 || dec_pred_target[3] !== 64'h9000_0000) begin
      errors++; $display("FAIL trunc_pred got=%b/%h exp=1/90000000", dec_pred_taken[3], dec_pred_target[3]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({dec_inst[i], dec_pc[i], dec_pred_taken[i], dec_pred_target[i]} !== sb[i]) begin
        errors++; $display("FAIL trunc_lane%0d got=%h exp=%h", i,
          {dec_inst[i], dec_pc[i], dec_pred_taken[i], dec_pred_target[i]}, sb[i]);
      end
    end
    step(4, 1'b0, 1'b0);
    $display("test_truncate done: occ=%0d", occupancy);
  endtask

  task automatic test_sparse();
    logic [2:0][31:0] exp_inst;
    // Lane 0 is invalid but marked taken: it must not truncate the group.
    drive_group(64'h8000_2000, 12'h0A2, 12'h001, 64'h9100_0000);
    exp_inst[0] = fetch_inst[1];
    exp_inst[1] = fetch_inst[5];
    exp_inst[2] = fetch_inst[7];
    step(0, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 6'd3) begin errors++; $display("FAIL sparse_occ got=%0d exp=3", occupancy); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dec_inst[i] !== exp_inst[i]) begin
        errors++; $display("FAIL sparse_inst%0d got=%h exp=%h", i, dec_inst[i], exp_inst[i]);
      end
    end
    checks++;
    if (dec_pc[2] !== 64'h8000_201C) begin errors++; $display("FAIL sparse_pc2 got=%h exp=8000201c", dec_pc[2]); end
    step(3, 1'b0, 1'b0);
    $display("test_sparse done: occ=%0d", occupancy);
  endtask

  task automatic test_full();
    drive_group(64'h8000_3000, 12'hFFF, '0, '0);
    step(0, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 6'd12 || fetch_stall !== 1'b0) begin
      errors++; $display("FAIL full_g1 got=%0d/%b exp=12/0", occupancy, fetch_stall);
    end
    drive_group(64'h8000_3030, 12'hFFF, '0, '0);
    step(0, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 6'd24 || fetch_stall !== 1'b1) begin
      errors++; $display("FAIL full_g2 got=%0d/%b exp=24/1", occupancy, fetch_stall);
    end
    drive_group(64'h8000_3060, 12'hFFF, '0, '0);
    step(0, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 6'd24) begin errors++; $display("FAIL full_ignored got=%0d exp=24", occupancy); end
    drive_group(64'h8000_3060, 12'hFFF, '0, '0);
    step(4, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 6'd20 || fetch_stall !== 1'b0) begin
      errors++; $display("FAIL full_release got=%0d/%b exp=20/0", occupancy, fetch_stall);
    end
    for (int i = 0; i < DW; i++) begin
      checks++;
      if ({dec_inst[i], dec_pc[i], dec_pred_taken[i], dec_pred_target[i]} !== sb[i]) begin
        errors++; $display("FAIL full_lane%0d got=%h exp=%h", i,
          {dec_inst[i], dec_pc[i], dec_pred_taken[i], dec_pred_target[i]}, sb[i]);
      end
    end
    checks++;
    if (dec_pc[0] !== 64'h8000_3010) begin errors++; $display("FAIL full_head_pc got=%h exp=80003010", dec_pc[0]); end
    step(12, 1'b0, 1'b0);
    step(8, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 6'd0) begin errors++; $display("FAIL full_drain got=%0d exp=0", occupancy); end
    $display("test_full done: occ=%0d", occupancy);
  endtask

  task automatic test_wrap();
    logic [VW-1:0] exp_pc = 64'h8001_0000;
    drive_group(64'h8001_0000, 12'hFFF, '0, '0);
    step(0, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      drive_group(64'h8001_0000 + VW'(48 * c), 12'hFFF, '0, '0);
      checks++;
      if (occupancy !== 6'd12) begin errors++; $display("FAIL wrap_occ c%0d got=%0d exp=12", c, occupancy); end
      for (int i = 0; i < DW; i++) begin
        checks++;
        if (dec_pc[i] !== exp_pc || dec_valid[i] !== 1'b1 ||
            {dec_inst[i], dec_pc[i], dec_pred_taken[i], dec_pred_target[i]} !== sb[i]) begin
          errors++; $display("FAIL wrap_lane c%0d l%0d got=%h pc=%h exp_pc=%h", c, i,
            {dec_inst[i], dec_pc[i], dec_pred_taken[i], dec_pred_target[i]}, dec_pc[i], exp_pc);
        end
        exp_pc = exp_pc + 64'd4;
      end
      step(12, 1'b0, 1'b0);
    end
    step(12, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 6'd0) begin errors++; $display("FAIL wrap_drain got=%0d exp=0", occupancy); end
    $display("test_wrap done: occ=%0d", occupancy);
  endtask

  task automatic test_flush();
    drive_group(64'h8002_0000, 12'hFFF, '0, '0);
    step(0, 1'b0, 1'b0);
    drive_group(64'h8002_0030, 12'hFFF, '0, '0);
    step(0, 1'b0, 1'b0);
    step(4, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 6'd20) begin errors++; $display("FAIL flush_pre got=%0d exp=20", occupancy); end
    drive_group(64'h8002_0060, 12'hFFF, '0, '0);
    step(5, 1'b1, 1'b0);
    checks++;
    if (occupancy !== 6'd0 || dec_valid !== '0 || fetch_stall !== 1'b0) begin
      errors++; $display("FAIL flush_post got=%0d/%h/%b exp=0/0/0", occupancy, dec_valid, fetch_stall);
    end
    $display("test_flush done: occ=%0d", occupancy);
  endtask

  task automatic test_rst_mid();
    drive_group(64'h8003_0000, 12'hFFF, '0, '0);
    step(0, 1'b0, 1'b0);
    drive_group(64'h8003_0030, 12'hFFF, '0, '0);
    step(0, 1'b1, 1'b1);
    checks++;
    if (occupancy !== 6'd0 || dec_valid !== '0) begin
      errors++; $display("FAIL rst_mid got=%0d/%h exp=0/0", occupancy, dec_valid);
    end
    drive_group(64'h8003_1000, 12'h007, '0, '0);
    step(0, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 6'd3) begin errors++; $display("FAIL rst_reuse_occ got=%0d exp=3", occupancy); end
    for (int i = 0; i < DW; i++) begin
      checks++;
      if (i < 3) begin
        if ({dec_inst[i], dec_pc[i], dec_pred_taken[i], dec_pred_target[i]} !== sb[i]) begin
          errors++; $display("FAIL rst_reuse_lane%0d got=%h exp=%h", i,
            {dec_inst[i], dec_pc[i], dec_pred_taken[i], dec_pred_target[i]}, sb[i]);
        end
      end else if (dec_valid[i] !== 1'b0 || dec_inst[i] !== 32'h13 || dec_pc[i] !== '0) begin
        errors++; $display("FAIL rst_reuse_nop%0d got=%b/%h/%h exp=0/13/0", i, dec_valid[i], dec_inst[i], dec_pc[i]);
      end
    end
    step(3, 1'b0, 1'b0);
    $display("test_rst_mid done: occ=%0d", occupancy);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dec_take = '0;
    fetch_valid = '0;
    test_reset();
    test_basic();
    test_truncate();
    test_sparse();
    test_full();
    test_wrap();
    test_flush();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
